// File: rtl/concat_sched_4i.sv
// Four-branch concatenation scheduler: addresses per-branch write buffers, then drains them in branch order.
// Optional macro CONCAT_OVERLAP_EN lets draining start once branch 1 is full while later branches still fill.
module concat_sched_4i #(
    parameter int D      = 220,
    parameter int C_1    = 1,
    parameter int C_2    = 1,
    parameter int C_3    = 1,
    parameter int C_4    = 1,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        valid_in,
    output logic [3:0]        wr_en,
    output logic [ADDR_W-1:0] wr_addr_1,
    output logic [ADDR_W-1:0] wr_addr_2,
    output logic [ADDR_W-1:0] wr_addr_3,
    output logic [ADDR_W-1:0] wr_addr_4,
    output logic              rd_en,
    output logic [1:0]        rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              out_ready,
    output logic              valid_out,
    output logic              busy,
    output logic              done,
    output logic              overflow_err
);

    localparam logic [ADDR_W-1:0] T_1 = ADDR_W'(D * D * C_1);
    localparam logic [ADDR_W-1:0] T_2 = ADDR_W'(D * D * C_2);
    localparam logic [ADDR_W-1:0] T_3 = ADDR_W'(D * D * C_3);
    localparam logic [ADDR_W-1:0] T_4 = ADDR_W'(D * D * C_4);

    typedef enum logic [2:0] {
        IDLE, FILL, DRAIN_1, DRAIN_2, DRAIN_3, DRAIN_4, DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt   [4];
    logic [ADDR_W-1:0] t_len [4];
    logic [ADDR_W-1:0] rd_cnt;
    logic [3:0]        full;
    logic [3:0]        ovf_hit;
    logic [1:0]        drain_idx;
    logic              in_fill, in_drain, wr_window, drain_ok, fill_exit;
    logic              rd_last, start_acc;

    assign t_len[0] = T_1;
    assign t_len[1] = T_2;
    assign t_len[2] = T_3;
    assign t_len[3] = T_4;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        in_fill   = (state == FILL);
        in_drain  = 1'b0;
        drain_idx = 2'd0;
        case (state)
            DRAIN_1: begin in_drain = 1'b1; drain_idx = 2'd0; end
            DRAIN_2: begin in_drain = 1'b1; drain_idx = 2'd1; end
            DRAIN_3: begin in_drain = 1'b1; drain_idx = 2'd2; end
            DRAIN_4: begin in_drain = 1'b1; drain_idx = 2'd3; end
            default: ;
        endcase
        for (int k = 0; k < 4; k++) full[k] = (cnt[k] == t_len[k]);
    end

`ifdef CONCAT_OVERLAP_EN
    assign wr_window = in_fill | in_drain;
    assign drain_ok  = full[drain_idx];
    assign fill_exit = full[0];
    assign ovf_hit   = valid_in & full & {4{wr_window}};
`else
    assign wr_window = in_fill;
    assign drain_ok  = 1'b1;
    assign fill_exit = &full;
    // Buffers are being read out, so any write attempt while draining is a protocol error.
    assign ovf_hit   = (valid_in & full & {4{in_fill}}) | (valid_in & {4{in_drain}});
`endif

    assign wr_en     = valid_in & ~full & {4{wr_window}};
    assign wr_addr_1 = cnt[0];
    assign wr_addr_2 = cnt[1];
    assign wr_addr_3 = cnt[2];
    assign wr_addr_4 = cnt[3];

    assign rd_en     = in_drain & out_ready & drain_ok;
    assign rd_sel    = drain_idx;
    assign rd_addr   = in_drain ? rd_cnt : '0;
    assign rd_last   = rd_en & (rd_cnt == (t_len[drain_idx] - ADDR_W'(1)));

    assign start_acc = (state == IDLE) & start;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)     state_nx = FILL;
            FILL:    if (fill_exit) state_nx = DRAIN_1;
            DRAIN_1: if (rd_last)   state_nx = DRAIN_2;
            DRAIN_2: if (rd_last)   state_nx = DRAIN_3;
            DRAIN_3: if (rd_last)   state_nx = DRAIN_4;
            DRAIN_4: if (rd_last)   state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            valid_out    <= 1'b0;
            overflow_err <= 1'b0;
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
        end else begin
            state     <= state_nx;
            valid_out <= rd_en;

            if (start_acc)     overflow_err <= 1'b0;
            else if (|ovf_hit) overflow_err <= 1'b1;

            if (start_acc || rd_last) rd_cnt <= '0;
            else if (rd_en)           rd_cnt <= rd_cnt + ADDR_W'(1);

            for (int k = 0; k < 4; k++) begin
                if (start_acc)     cnt[k] <= '0;
                else if (wr_en[k]) cnt[k] <= cnt[k] + ADDR_W'(1);
            end
        end
    end

endmodule

// File: doc/concat_sched_4i.md
CONCAT_SCHED_4I -- requirements
Module: concat_sched_4i

Interface
REQ-001 SHALL have parameter D, default 220: feature-map side length.
REQ-002 SHALL have parameters C_1, C_2, C_3, C_4, default 1 each: channel count of each branch; T_k = D*D*C_k words per branch.
REQ-003 SHALL have parameter ADDR_W, default 20: buffer address width, with 2^ADDR_W > max(T_k).
REQ-004 SHALL have ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a new frame.
- valid_in, input, 4: per-branch write strobe; bit k-1 corresponds to branch k.
- wr_en, output, 4: per-branch buffer write enable.
- wr_addr_1..wr_addr_4, output, ADDR_W each: per-branch buffer write address.
- rd_en, output, 1: buffer read strobe.
- rd_sel, output, 2: branch being read (0..3 = branch 1..4).
- rd_addr, output, ADDR_W: read address.
- out_ready, input, 1: downstream can accept.
- valid_out, output, 1: merged-stream word valid, aligned with 1-cycle buffer read data.
- busy, output, 1: frame in progress.
- done, output, 1: end-of-frame pulse.
- overflow_err, output, 1: sticky error flag.

Function
REQ-005 SHALL implement the FSM states IDLE, FILL, DRAIN_1, DRAIN_2, DRAIN_3, DRAIN_4 and DONE.
REQ-006 IDLE: on start=1, SHALL clear the write counters cnt_k and the read counter, then go to FILL; valid_in SHALL be ignored in IDLE.
REQ-007 wr_en[k] SHALL be combinational: valid_in[k] AND state is not IDLE/DONE AND cnt_k < T_k; wr_addr_k SHALL equal cnt_k; cnt_k SHALL increment on each wr_en[k].
REQ-008 valid_in[k] arriving while cnt_k == T_k SHALL suppress the write and set overflow_err.
REQ-009 FILL SHALL go to DRAIN_1 in the cycle after all cnt_k == T_k are seen.
REQ-010 In DRAIN_k, the block SHALL issue rd_en = out_ready, with rd_sel = k-1 and rd_addr = the read counter, which advances only on rd_en.
REQ-011 When the read at address T_k-1 is issued, the block SHALL clear the read counter and go to DRAIN_k+1; from DRAIN_4 it SHALL go to DONE.
REQ-012 There SHALL be no idle cycle between branches when out_ready stays high: the output is exactly T_1+T_2+T_3+T_4 contiguous beats, in branch order.
REQ-013 valid_out SHALL be rd_en registered by one cycle.
- out_ready is sampled at issue.
- Downstream SHALL absorb one beat after deasserting out_ready.
REQ-014 DONE SHALL last one cycle, with done=1 coinciding with the final valid_out, then return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 In DRAIN states, non-overlap build: any valid_in SHALL set overflow_err and SHALL NOT write.
REQ-018 overflow_err SHALL clear only on reset or on start accepted from IDLE.

Reset
REQ-019 On reset=1, SHALL go asynchronously to IDLE and drive:
- all counters = 0
- wr_en = 0, rd_en = 0, valid_out = 0, done = 0, busy = 0, overflow_err = 0
- rd_sel = 0, rd_addr = 0
REQ-020 Reset mid-frame SHALL abandon the frame; no done SHALL be produced, and the next frame requires start.

Configuration
REQ-021 Macro CONCAT_OVERLAP_EN, when defined:
- FILL SHALL go to DRAIN_1 as soon as cnt_1 == T_1.
- DRAIN_k SHALL hold rd_en=0 (stall) until cnt_k == T_k.
- Writes to branches not yet full SHALL continue during DRAIN states without error.
- REQ-012 holds only when each branch is complete before its turn.
REQ-022 Without CONCAT_OVERLAP_EN, draining SHALL wait for all four branches, per REQ-009 and REQ-017.

Verification (D=2, C_k=1, so T_k=4, unless stated)
REQ-023 Base: start; 4 writes per branch, interleaved; out_ready=1 -> 16 contiguous valid_out beats; rd_sel 0,0,0,0,1,...,3; rd_addr 0..3 each; done on beat 16.
REQ-024 Backpressure: out_ready low for 3 cycles mid-DRAIN_2 -> exactly one beat after the drop, no address skipped or repeated, total 16 beats.
REQ-025 Overflow: 5th valid_in[2] in FILL -> wr_en[2]=0, overflow_err=1 and held until the next start.
REQ-026 Reset at beat 6 -> all outputs 0 next cycle, no done; a new start completes a clean 16-beat frame.
REQ-027 C_1=2 (T_1=8), CONCAT_OVERLAP_EN defined, branch 4 finishes last -> DRAIN_1 begins before branch 4 is full; stall in DRAIN_4 until cnt_4=4; 20 beats in total.
REQ-028 start asserted while busy -> no effect; valid_in in IDLE -> no wr_en.
